// File: rtl/d_alu_pkg.sv
// Shared opcode constants and the packed result bundle for the d_alu slice.
package d_alu_pkg;

   localparam logic [7:0] xADD  = 8'h01;
   localparam logic [7:0] xADC  = 8'h02;
   localparam logic [7:0] xSUB  = 8'h03;
   localparam logic [7:0] xSUC  = 8'h04;
   localparam logic [7:0] xMUL8 = 8'h05;
   localparam logic [7:0] xMUL6 = 8'h06;
   localparam logic [7:0] xDIV8 = 8'h07;
   localparam logic [7:0] xDIV6 = 8'h08;
   localparam logic [7:0] xCMP  = 8'h09;
   localparam logic [7:0] xAND  = 8'h0A;
   localparam logic [7:0] xNEG  = 8'h0B;
   localparam logic [7:0] xNOT  = 8'h0C;
   localparam logic [7:0] xOR   = 8'h0D;
   localparam logic [7:0] xSHL  = 8'h0E;
   localparam logic [7:0] xSHR  = 8'h0F;
   localparam logic [7:0] xXOR  = 8'h10;
   localparam logic [7:0] xTEST = 8'h11;

   typedef struct packed {
      logic [15:0] acc;
      logic [15:0] c;
      logic        cFlag;
      logic        zFlag;
      logic        oFlag;
   } aluResult_t;

endpackage

// File: rtl/d_alu_div.sv
// Combinational unsigned divider; a zero divisor yields an all-ones quotient
// and passes the dividend through as the remainder.
module d_alu_div #(
   parameter int W = 16
) (
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] quotient_o,
   output logic [W-1:0] remainder_o,
   output logic         divByZero_o
);

   assign divByZero_o = (divisor_i == '0);

   always_comb begin
      quotient_o  = '1;
      remainder_o = dividend_i;
      if (!divByZero_o) begin
         quotient_o  = dividend_i / divisor_i;
         remainder_o = dividend_i % divisor_i;
      end
   end

endmodule

// File: rtl/d_alu.sv
// 16-bit CPU ALU: opcode mux and flag logic. Define D_ALU_OUTREG_EN to add a
// 1-cycle output register stage with asynchronous active-low reset.
module d_alu
   import d_alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [7:0]  op,
   input  logic        cf,
   output logic [15:0] acc,
   output logic [15:0] c,
   output logic        c_flag,
   output logic        z_flag,
   output logic        o_flag
);

   aluResult_t  resD;
   logic        addCarry;
   logic        subBorrow;
   logic [16:0] sum17;
   logic [16:0] diff17;
   logic [15:0] mul8;
   logic [31:0] prod32;
   logic [7:0]  quot8;
   logic [7:0]  rem8;
   logic        divZero8;
   logic [15:0] quot16;
   logic [15:0] rem16;
   logic        divZero16;
   logic        opValid;

   // Carry-in only participates in ADC/SUC; bit 16 of diff17 is the borrow.
   assign addCarry  = (op == xADC) && cf;
   assign subBorrow = (op == xSUC) && cf;
   assign sum17     = {1'b0, a} + {1'b0, b} + {16'b0, addCarry};
   assign diff17    = {1'b0, b} - {1'b0, a} - {16'b0, subBorrow};
   assign mul8      = {8'b0, a[7:0]} * {8'b0, b[7:0]};
   assign prod32    = {16'b0, a} * {16'b0, b};

   d_alu_div #(.W(8)) uDiv8 (
      .dividend_i  (b[7:0]),
      .divisor_i   (a[7:0]),
      .quotient_o  (quot8),
      .remainder_o (rem8),
      .divByZero_o (divZero8)
   );

   d_alu_div #(.W(16)) uDiv16 (
      .dividend_i  (b),
      .divisor_i   (a),
      .quotient_o  (quot16),
      .remainder_o (rem16),
      .divByZero_o (divZero16)
   );

   always_comb begin
      resD    = '0;
      opValid = 1'b1;
      unique case (op)
         xADD, xADC: begin
            resD.acc   = sum17[15:0];
            resD.cFlag = sum17[16];
            resD.oFlag = (a[15] == b[15]) && (sum17[15] != a[15]);
         end
         xSUB, xSUC, xCMP: begin
            resD.acc   = diff17[15:0];
            resD.cFlag = diff17[16];
            resD.oFlag = (a[15] != b[15]) && (diff17[15] != b[15]);
         end
         xMUL8: resD.acc = mul8;
         xMUL6: {resD.c, resD.acc} = prod32;
         xDIV8: begin
            resD.acc   = {rem8, quot8};
            resD.oFlag = divZero8;
         end
         xDIV6: begin
            resD.acc   = quot16;
            resD.c     = rem16;
            resD.oFlag = divZero16;
         end
         xAND, xTEST: resD.acc = a & b;
         xNEG: begin
            resD.acc   = 16'd0 - a;
            resD.cFlag = (a != 16'd0);
            resD.oFlag = (a == 16'h8000);
         end
         xNOT: resD.acc = ~a;
         xOR:  resD.acc = a | b;
         xSHL: begin
            resD.acc   = {a[14:0], 1'b0};
            resD.cFlag = a[15];
         end
         xSHR: begin
            resD.acc   = {1'b0, a[15:1]};
            resD.cFlag = a[0];
         end
         xXOR: resD.acc = a ^ b;
         default: opValid = 1'b0;
      endcase
      // MUL6 judges zero on the whole 32-bit product, not just the low word.
      if (op == xMUL6)
         resD.zFlag = (prod32 == 32'd0);
      else if (opValid)
         resD.zFlag = (resD.acc == 16'd0);
   end

`ifdef D_ALU_OUTREG_EN
   aluResult_t resQ;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         resQ <= '0;
      else
         resQ <= resD;
   end

   assign acc    = resQ.acc;
   assign c      = resQ.c;
   assign c_flag = resQ.cFlag;
   assign z_flag = resQ.zFlag;
   assign o_flag = resQ.oFlag;
`else
   logic unusedClkReset;
   assign unusedClkReset = clk ^ reset;

   assign acc    = resD.acc;
   assign c      = resD.c;
   assign c_flag = resD.cFlag;
   assign z_flag = resD.zFlag;
   assign o_flag = resD.oFlag;
`endif

endmodule

// File: tb/tb_d_alu.sv
// Scoreboard bench for d_alu; expected results are queued when operands are
// driven and compared one clock later, which suits both build variants.
module tb_d_alu;

   logic        clk;
   logic        reset;
   logic [15:0] a;
   logic [15:0] b;
   logic [7:0]  op;
   logic        cf;
   logic [15:0] acc;
   logic [15:0] c;
   logic        c_flag;
   logic        z_flag;
   logic        o_flag;

   typedef struct {
      string       tag;
      logic [15:0] acc;
      logic [15:0] c;
      logic [2:0]  flags;
   } expect_t;

   expect_t sbQueue[$];
   int      assertCount = 0;
   int      failCount   = 0;

   d_alu dut (
      .clk    (clk),
      .reset  (reset),
      .a      (a),
      .b      (b),
      .op     (op),
      .cf     (cf),
      .acc    (acc),
      .c      (c),
      .c_flag (c_flag),
      .z_flag (z_flag),
      .o_flag (o_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Independent reference written with plain integer arithmetic.
   function automatic expect_t model(input logic [15:0] ma, input logic [15:0] mb,
                                     input logic [7:0] mop, input logic mcf);
      expect_t     e;
      int          s;
      longint      p;
      logic [15:0] r;
      logic        cOut;
      logic        oOut;
      logic        zOut;
      logic        zFromAcc;
      r = 16'd0; e.c = 16'd0; cOut = 1'b0; oOut = 1'b0; zOut = 1'b0;
      zFromAcc = 1'b1;
      case (mop)
         8'h01, 8'h02: begin
            s = int'(ma) + int'(mb) + ((mop == 8'h02) ? int'(mcf) : 0);
            r = s[15:0];
            cOut = (s > 65535);
            oOut = (ma[15] == mb[15]) && (r[15] != ma[15]);
         end
         8'h03, 8'h04, 8'h09: begin
            s = int'(mb) - int'(ma) - ((mop == 8'h04) ? int'(mcf) : 0);
            r = s[15:0];
            cOut = (s < 0);
            oOut = (ma[15] != mb[15]) && (r[15] != mb[15]);
         end
         8'h05: begin
            s = int'(ma[7:0]) * int'(mb[7:0]);
            r = s[15:0];
         end
         8'h06: begin
            p = longint'(ma) * longint'(mb);
            r = p[15:0];
            e.c = p[31:16];
            zOut = (p == 0);
            zFromAcc = 1'b0;
         end
         8'h07: begin
            if (ma[7:0] == 8'd0) begin
               r = {mb[7:0], 8'hFF};
               oOut = 1'b1;
            end else begin
               r[7:0]  = mb[7:0] / ma[7:0];
               r[15:8] = mb[7:0] % ma[7:0];
            end
         end
         8'h08: begin
            if (ma == 16'd0) begin
               r = 16'hFFFF;
               e.c = mb;
               oOut = 1'b1;
            end else begin
               r = mb / ma;
               e.c = mb % ma;
            end
         end
         8'h0A, 8'h11: r = ma & mb;
         8'h0B: begin
            s = 65536 - int'(ma);
            r = s[15:0];
            cOut = (ma != 16'd0);
            oOut = (ma == 16'h8000);
         end
         8'h0C: r = ~ma;
         8'h0D: r = ma | mb;
         8'h0E: begin
            s = int'(ma) * 2;
            r = s[15:0];
            cOut = (ma >= 16'h8000);
         end
         8'h0F: begin
            r = ma / 2;
            cOut = (ma % 2 == 1);
         end
         8'h10: r = ma ^ mb;
         default: zFromAcc = 1'b0;
      endcase
      if (zFromAcc) zOut = (r == 16'd0);
      e.acc = r;
      e.flags = {cOut, zOut, oOut};
      return e;
   endfunction

   task automatic compareNext();
      expect_t e;
      if (sbQueue.size() > 0) begin
         e = sbQueue.pop_front();
         checkOutput({e.tag, "-acc"}, {16'd0, acc}, {16'd0, e.acc});
         checkOutput({e.tag, "-c"}, {16'd0, c}, {16'd0, e.c});
         checkOutput({e.tag, "-flags"}, {29'd0, c_flag, z_flag, o_flag}, {29'd0, e.flags});
      end
   endtask

   task automatic stepDrive(input logic [15:0] sa, input logic [15:0] sb,
                            input logic [7:0] sop, input logic scf);
      @(posedge clk);
      #1;
      compareNext();
      a = sa; b = sb; op = sop; cf = scf;
   endtask

   task automatic applyStimulus(input string tag, input logic [15:0] sa,
                                input logic [15:0] sb, input logic [7:0] sop,
                                input logic scf);
      expect_t e;
      stepDrive(sa, sb, sop, scf);
      e = model(sa, sb, sop, scf);
      e.tag = tag;
      sbQueue.push_back(e);
   endtask

   task automatic applyKnown(input string tag, input logic [15:0] sa,
                             input logic [15:0] sb, input logic [7:0] sop,
                             input logic scf, input logic [15:0] eAcc,
                             input logic [15:0] eC, input logic [2:0] eFlags);
      expect_t e;
      stepDrive(sa, sb, sop, scf);
      e.tag = tag; e.acc = eAcc; e.c = eC; e.flags = eFlags;
      sbQueue.push_back(e);
   endtask

   initial begin
      logic [7:0]  rop;
      logic [15:0] ra;
      logic [15:0] rb;
      reset = 1'b0;
      a = 16'd0; b = 16'd0; op = 8'h00; cf = 1'b0;
      repeat (3) @(posedge clk);
`ifdef D_ALU_OUTREG_EN
      #1;
      checkOutput("resetAcc", {16'd0, acc}, 32'd0);
      checkOutput("resetC", {16'd0, c}, 32'd0);
      checkOutput("resetFlags", {29'd0, c_flag, z_flag, o_flag}, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b1;

      // Flags below are ordered {c_flag, z_flag, o_flag}.
      applyKnown("addWrap",   16'hFFFF, 16'h0001, 8'h01, 1'b0, 16'h0000, 16'h0000, 3'b110);
      applyKnown("addOvf",    16'h7FFF, 16'h0001, 8'h01, 1'b0, 16'h8000, 16'h0000, 3'b001);
      applyKnown("adcCarry",  16'h0001, 16'h0001, 8'h02, 1'b1, 16'h0003, 16'h0000, 3'b000);
      applyKnown("addIgnCf",  16'h0001, 16'h0001, 8'h01, 1'b1, 16'h0002, 16'h0000, 3'b000);
      applyKnown("subBorrow", 16'h0001, 16'h0000, 8'h03, 1'b0, 16'hFFFF, 16'h0000, 3'b100);
      applyKnown("sucBorrow", 16'h0000, 16'h0000, 8'h04, 1'b1, 16'hFFFF, 16'h0000, 3'b100);
      applyKnown("cmpEqual",  16'h0005, 16'h0005, 8'h09, 1'b1, 16'h0000, 16'h0000, 3'b010);
      applyKnown("mul6",      16'h1234, 16'h0100, 8'h06, 1'b0, 16'h3400, 16'h0012, 3'b000);
      applyKnown("mul6HiOnly",16'h8000, 16'h0002, 8'h06, 1'b0, 16'h0000, 16'h0001, 3'b000);
      applyKnown("mul8",      16'hFF10, 16'h0010, 8'h05, 1'b0, 16'h0100, 16'h0000, 3'b000);
      applyKnown("div6",      16'h0007, 16'd100,  8'h08, 1'b0, 16'd14,   16'd2,    3'b000);
      applyKnown("div6Zero",  16'h0000, 16'h0005, 8'h08, 1'b0, 16'hFFFF, 16'h0005, 3'b001);
      applyKnown("div8Zero",  16'h0100, 16'h00AB, 8'h07, 1'b0, 16'hABFF, 16'h0000, 3'b001);
      applyKnown("div8",      16'h0003, 16'hFF0A, 8'h07, 1'b0, 16'h0103, 16'h0000, 3'b000);
      applyKnown("shl",       16'h8001, 16'h1234, 8'h0E, 1'b0, 16'h0002, 16'h0000, 3'b100);
      applyKnown("shr",       16'h8001, 16'h1234, 8'h0F, 1'b0, 16'h4000, 16'h0000, 3'b100);
      applyKnown("neg1",      16'h0001, 16'h0000, 8'h0B, 1'b0, 16'hFFFF, 16'h0000, 3'b100);
      applyKnown("negMin",    16'h8000, 16'h0000, 8'h0B, 1'b0, 16'h8000, 16'h0000, 3'b101);
      applyKnown("testZero",  16'h00F0, 16'h0F00, 8'h11, 1'b0, 16'h0000, 16'h0000, 3'b010);
      applyKnown("undef55",   16'h1234, 16'h5678, 8'h55, 1'b1, 16'h0000, 16'h0000, 3'b000);
      applyKnown("undef00",   16'h0000, 16'h0000, 8'h00, 1'b0, 16'h0000, 16'h0000, 3'b000);

      for (int i = 0; i < 60; i++) begin
         rop = 8'($urandom_range(0, 19));
         if (i % 10 == 9) rop = 8'($urandom_range(18, 255));
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 7 == 0) ra = 16'd0;
         if (i % 11 == 0) ra[7:0] = 8'd0;
         applyStimulus($sformatf("rand%0d_op%0h", i, rop), ra, rb, rop, 1'($urandom));
      end

      @(posedge clk);
      #1;
      compareNext();

`ifdef D_ALU_OUTREG_EN
      a = 16'd9; b = 16'd9; op = 8'h01; cf = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("preResetAcc", {16'd0, acc}, 32'd18);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("asyncResetAcc", {16'd0, acc}, 32'd0);
      checkOutput("asyncResetFlags", {29'd0, c_flag, z_flag, o_flag}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("heldResetAcc", {16'd0, acc}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      a = 16'd2; b = 16'd3; op = 8'h01;
      @(posedge clk);
      #1;
      checkOutput("postReleaseAcc", {16'd0, acc}, 32'd5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/d_alu.md
# d_alu

Combinational 16-bit arithmetic/logic unit used by the CPU core for all ALU opcodes (add/sub with carry, 8- and 16-bit multiply/divide, compare, bitwise logic, shifts). Operands `a`, `b`, carry-in `cf` and opcode `op` produce a primary result `acc`, a secondary result `c` (high product word or remainder) and carry/zero/overflow flags. The CPU presents operands on one clock edge and consumes results on the next. An optional output register stage can be compiled in.

## Interface
- No parameters; opcode constants come from the shared package.
- `clk`  in  1  clock; used only by the optional output register stage.
- `reset`  in  1  asynchronous, active-low reset; clears the optional output registers.
- `a`  in  16  operand A: the CPU's dx for arithmetic, the destination register for logic ops.
- `b`  in  16  operand B: the CPU's ax for arithmetic, the source register for logic ops.
- `op`  in  8  operation code.
- `cf`  in  1  carry/borrow-in, used by ADC and SUC only.
- `acc`  out  16  primary result.
- `c`  out  16  secondary result: product high word (MUL6) or remainder (DIV6); 0 for all other ops.
- `c_flag`  out  1  carry / borrow / shifted-out bit.
- `z_flag`  out  1  result-zero flag.
- `o_flag`  out  1  signed overflow, or divide-by-zero.

## Operation
- 01 ADD: acc = a+b. c_flag is bit 16 of the sum. o_flag = (a[15]==b[15]) && (acc[15]!=a[15]).
- 02 ADC: acc = a+b+cf. Flags as ADD.
- 03 SUB: acc = b−a. c_flag = borrow (b<a unsigned). o_flag = (a[15]!=b[15]) && (acc[15]!=b[15]).
- 04 SUC: acc = b−a−cf. c_flag = borrow of the full subtraction. o_flag as SUB.
- 05 MUL8: acc = a[7:0]*b[7:0] (16-bit product).
- 06 MUL6: {c,acc} = a*b (unsigned 32-bit product). z_flag = (full 32-bit product == 0).
- 07 DIV8: acc[7:0] = b[7:0]/a[7:0] and acc[15:8] = b[7:0]%a[7:0], both unsigned.
- 08 DIV6: acc = b/a and c = b%a, both unsigned.
- Divide by zero (divisor a, or a[7:0] for DIV8):
  - quotient field is all ones and remainder field = dividend;
  - o_flag = 1.
- 09 CMP: acc = b−a. Flags exactly as SUB.
- Logic ops (c_flag = 0, o_flag = 0 unless stated):
  - 0A AND: acc = a&b.
  - 0B NEG: acc = −a (two's complement); c_flag = (a!=0); o_flag = (a==16'h8000).
  - 0C NOT: acc = ~a.
  - 0D OR: acc = a|b.
  - 0E SHL: acc = a<<1; c_flag = a[15].
  - 0F SHR: acc = a>>1 (logical); c_flag = a[0].
  - 10 XOR: acc = a^b.
  - 11 TEST: acc = a&b.
- Multiply and divide: c_flag = 0 always; o_flag = 0 except on divide by zero.
- z_flag = (acc==0) for every defined op except MUL6.
- Undefined op (including 00 and 12–FF): acc = 0, c = 0, all flags = 0.
- `b` is ignored by NEG/NOT/SHL/SHR. `cf` is ignored by every op except ADC and SUC.

## Timing
- Default build: pure combinational path from (a, b, op, cf) to all outputs, zero cycle latency. Outputs have no reset state; `clk` and `reset` are unused.
- CPU protocol: operands and op change after edge N; results are sampled by the CPU at edge N+1. The full path, including the 16-bit divider, must settle within one clock period.
- With the register stage compiled in:
  - all outputs update on posedge `clk`, latency 1 cycle;
  - `reset` low asynchronously forces acc = 0, c = 0 and all flags = 0, and holds them there while low;
  - the first capture happens on the first posedge after `reset` deasserts.

## Configuration
- `D_ALU_OUTREG_EN` defined: output register stage present, with the 1-cycle latency and async active-low reset described in Timing.
- `D_ALU_OUTREG_EN` undefined (default, required by the CPU core): combinational outputs.

## Structure
- Package `d_alu_pkg` holds the 8-bit opcode localparams (xADD..xTEST, values 01–11).
- Sub-module `d_alu_div` implements the combinational unsigned divider, with a width parameter (8/16). It outputs quotient and remainder and applies the divide-by-zero convention.
- The top level holds the opcode mux, flag logic and the optional register stage.

## Test plan
- ADD a=16'hFFFF, b=1 → acc=0, c_flag=1, z_flag=1, o_flag=0. ADD a=16'h7FFF, b=1 → acc=16'h8000, o_flag=1.
- ADC a=1, b=1, cf=1 → acc=3. SUB a=1, b=0 → acc=16'hFFFF, c_flag=1, z_flag=0.
- MUL6 a=16'h1234, b=16'h0100 → acc=16'h3400, c=16'h0012. MUL8 a=16'hFF10, b=16'h0010 → acc=16'h0100.
- DIV6 a=7, b=100 → acc=14, c=2. DIV6 a=0, b=5 → acc=16'hFFFF, c=5, o_flag=1.
- SHL a=16'h8001 → acc=16'h0002, c_flag=1. NEG a=1 → acc=16'hFFFF. TEST a=16'h00F0, b=16'h0F00 → z_flag=1. op=8'h55 → all outputs 0.
- With `D_ALU_OUTREG_EN`: reset low mid-operation clears outputs immediately. After release, ADD 2+3 appears on acc one posedge later.
